mpu_ctrl_fsm: RTL and testbench

Parametrised instruction controller for the matrix processing unit. Accepts one host instruction per valid/ready handshake and sequences the BRAM banks, the operand/destination muxes and the arithmetic units. Generalises bank count, row width and byte width. Adds flow-controlled byte streaming for LOAD/UNLOAD and start/done handshakes for multi-cycle arithmetic units. Sits between the host interface and the BRAM/ALU datapath.

---
 rtl/mpu_ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_mpu_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_ctrl_fsm.sv
// rtl/mpu_ctrl_fsm.sv - MPU instruction controller: host handshake, bank enables, byte streaming, unit sequencing
// Optional unit_done watchdog is compiled in when MPU_OP_TIMEOUT_EN is defined.
module mpu_ctrl_fsm #(
  parameter int NUM_BANKS   = 4,
  parameter int DATA_W      = 512,
  parameter int BYTE_W      = 8,
  parameter int OFF_W       = $clog2(DATA_W),
  parameter int TIMEOUT_CYC = 1024,
  localparam int SEL_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4+2*SEL_W-1:0] instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 byte_valid,
  input  logic                 byte_ready,
  input  logic                 unit_done,
  output logic [OFF_W-1:0]     offset,
  output logic [SEL_W-1:0]     aa_sel,
  output logic [SEL_W-1:0]     dd_sel,
  output logic [1:0]           out_sel,
  output logic                 unit_start,
  output logic                 bram_in_sel,
  output logic [NUM_BANKS-1:0] bank_we,
  output logic [NUM_BANKS-1:0] bank_be,
  output logic [NUM_BANKS-1:0] bank_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_COPY   = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;
  localparam logic [2:0] S_EXEC   = 3'd6;
  localparam logic [2:0] S_WB     = 3'd7;

  localparam int BEATS = DATA_W / BYTE_W;
  localparam logic [OFF_W-1:0] OFF_FIRST = OFF_W'(BYTE_W - 1);
  localparam logic [OFF_W-1:0] OFF_STEP  = OFF_W'(BYTE_W);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BEATS - 1);

  if (NUM_BANKS < 2 || NUM_BANKS > 16 || BYTE_W < 1 || (DATA_W % BYTE_W) != 0 || TIMEOUT_CYC < 1)
  begin : g_param_check
    $error("mpu_ctrl_fsm: illegal parameter combination");
  end

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 rst_released;
  logic                 exec_first;
  logic [OFF_W-1:0]     beat_cnt;
  logic                 done_nxt;
  logic                 err_nxt;
  logic [3:0]           op;
  logic [SEL_W-1:0]     instr_aa;
  logic [SEL_W-1:0]     instr_dd;
  logic                 accept;
  logic                 bad_bank;
  logic                 beat_adv;
  logic                 last_beat;
  logic [NUM_BANKS-1:0] dd_onehot;

  assign op        = instr[3:0];
  assign instr_aa  = instr[SEL_W+3:4];
  assign instr_dd  = instr[2*SEL_W+3:SEL_W+4];
  assign accept    = instr_valid && instr_ready;
  assign bad_bank  = (int'(instr_dd) >= NUM_BANKS) || (int'(instr_aa) >= NUM_BANKS);
  assign beat_adv  = ((state == S_LOAD) && byte_valid) || ((state == S_UNLOAD) && byte_ready);
  assign last_beat = (beat_cnt == LAST_BEAT);

`ifdef MPU_OP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == S_EXEC) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_INIT: begin
        if (rst_released) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          if (op[3:2] == 2'b00) begin
            done_nxt = 1'b1;
          end else if (bad_bank) begin
            err_nxt = 1'b1;
          end else begin
            case (op)
              4'b0100: state_nxt = S_LOAD;
              4'b0110: state_nxt = S_UNLOAD;
              4'b0101: state_nxt = S_COPY;
              4'b0111: state_nxt = S_CLEAR;
              4'b1100, 4'b1101, 4'b1110, 4'b1111: state_nxt = S_EXEC;
              default: err_nxt = 1'b1;
            endcase
          end
        end
      end
      S_LOAD, S_UNLOAD: begin
        if (beat_adv && last_beat) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      S_COPY, S_CLEAR, S_WB: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      S_EXEC: begin
        if (unit_done) state_nxt = S_WB;
`ifdef MPU_OP_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
`endif
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // rst_released distinguishes "held in reset" (all quiet) from the single INIT clear cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_INIT;
      rst_released <= 1'b0;
      exec_first   <= 1'b0;
      beat_cnt     <= '0;
      offset       <= '0;
      aa_sel       <= '0;
      dd_sel       <= '0;
      out_sel      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      rst_released <= 1'b1;
      done         <= done_nxt;
      err          <= err_nxt;
      exec_first   <= (state == S_IDLE) && (state_nxt == S_EXEC);
      if (accept) begin
        aa_sel <= instr_aa;
        dd_sel <= instr_dd;
      end
      if ((state == S_IDLE) && (state_nxt == S_EXEC)) out_sel <= op[1:0];
      if (state_nxt == S_IDLE) begin
        beat_cnt <= '0;
        offset   <= OFF_FIRST;
      end else if (beat_adv) begin
        beat_cnt <= beat_cnt + OFF_W'(1);
        offset   <= offset + OFF_STEP;
      end
    end
  end

  assign dd_onehot   = NUM_BANKS'(1) << dd_sel;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE) && !((state == S_INIT) && !rst_released);
  assign unit_start  = (state == S_EXEC) && exec_first;
  assign bram_in_sel = (state == S_COPY);
  assign bank_we     = ((state == S_COPY) || (state == S_WB)) ? dd_onehot : '0;
  assign bank_be     = ((state == S_LOAD) && byte_valid) ? dd_onehot : '0;

  always_comb begin
    bank_rst = '0;
    if ((state == S_INIT) && rst_released) bank_rst = '1;
    else if (state == S_CLEAR) bank_rst = dd_onehot;
  end

endmodule

// File: tb/tb_mpu_ctrl_fsm.sv
// tb/tb_mpu_ctrl_fsm.sv - scoreboard bench for mpu_ctrl_fsm
// Events (enables, start, done, err) are queued at stimulus time and matched on the falling edge.
module tb_mpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] instr;
  logic       instr_valid, instr_ready, byte_valid, byte_ready, unit_done;
  logic [8:0] offset;
  logic [1:0] aa_sel, dd_sel, out_sel;
  logic       unit_start, bram_in_sel, busy, done, err;
  logic [3:0] bank_we, bank_be, bank_rst;

  logic [7:0] instr3;
  logic       instr_valid3, instr_ready3, byte_valid3;
  logic [8:0] offset3;
  logic [1:0] aa_sel3, dd_sel3, out_sel3;
  logic       unit_start3, bram_in_sel3, busy3, done3, err3;
  logic [2:0] bank_we3, bank_be3, bank_rst3;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mpu_ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .unit_done(unit_done), .offset(offset), .aa_sel(aa_sel), .dd_sel(dd_sel),
    .out_sel(out_sel), .unit_start(unit_start), .bram_in_sel(bram_in_sel),
    .bank_we(bank_we), .bank_be(bank_be), .bank_rst(bank_rst), .busy(busy),
    .done(done), .err(err)
  );

  mpu_ctrl_fsm #(.NUM_BANKS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .instr(instr3), .instr_valid(instr_valid3),
    .instr_ready(instr_ready3), .byte_valid(byte_valid3), .byte_ready(byte_ready),
    .unit_done(unit_done), .offset(offset3), .aa_sel(aa_sel3), .dd_sel(dd_sel3),
    .out_sel(out_sel3), .unit_start(unit_start3), .bram_in_sel(bram_in_sel3),
    .bank_we(bank_we3), .bank_be(bank_be3), .bank_rst(bank_rst3), .busy(busy3),
    .done(done3), .err(err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [3:0] kind, input logic [11:0] aux, input logic [15:0] vec);
    return {kind, aux, vec};
  endfunction

  task automatic sb_match(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check_eq({"unexpected_", tag}, obs, 32'h0);
    else check_eq(tag, obs, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (bank_rst != '0) sb_match("bank_rst", ev(4'd1, 12'd0, 16'(bank_rst)));
    if (bank_be != '0)  sb_match("bank_be", ev(4'd2, 12'(offset), 16'(bank_be)));
    if (bank_we != '0)  sb_match("bank_we", ev(4'd3, 12'(bram_in_sel), 16'(bank_we)));
    if (unit_start)     sb_match("unit_start", ev(4'd4, 12'(out_sel), 16'd0));
    if (done)           sb_match("done", ev(4'd5, 12'd0, 16'd0));
    if (err)            sb_match("err", ev(4'd6, 12'd0, 16'd0));
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(instr_ready), 32'd1);
  endtask

  task automatic send_instr(input logic [7:0] i);
    wait_ready("instr_ready");
    instr = i;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = 8'($urandom);
  endtask

  task automatic push_done();
    exp_q.push_back(ev(4'd5, 12'd0, 16'd0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; instr = '0; instr_valid = 1'b0; byte_valid = 1'b0;
    byte_ready = 1'b0; unit_done = 1'b0;
    instr3 = '0; instr_valid3 = 1'b0; byte_valid3 = 1'b0;
    #3;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(instr_ready), 32'd0);
    check_eq("rst_offset", 32'(offset), 32'd0);
    check_eq("rst_sels", 32'({aa_sel, dd_sel, out_sel}), 32'd0);
    check_eq("rst_outs", 32'({bank_rst, bank_we, bank_be, unit_start, bram_in_sel, done, err}), 32'd0);

    exp_q.push_back(ev(4'd1, 12'd0, 16'hF));
    #19 reset_n = 1'b1;
    tick();
    check_eq("init_bank_rst", 32'(bank_rst), 32'hF);
    check_eq("init_busy", 32'(busy), 32'd1);
    tick();
    check_eq("idle_bank_rst", 32'(bank_rst), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_ready", 32'(instr_ready), 32'd1);
    check_eq("idle_offset", 32'(offset), 32'd7);

    // LOAD dd=2: 64 beats with three stalls
    for (int k = 0; k < 64; k++) exp_q.push_back(ev(4'd2, 12'(7 + 8 * k), 16'h0004));
    push_done();
    send_instr(8'h84);
    busy_cnt = 0;
    for (int c = 0; c < 67; c++) begin
      byte_valid = (c == 10 || c == 30 || c == 50) ? 1'b0 : 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    check_eq("load_busy_cycles", 32'(busy_cnt), 32'd67);
    check_eq("load_back_idle", 32'(instr_ready), 32'd1);
    check_eq("load_dd_sel", 32'(dd_sel), 32'd2);
    tick();
    check_eq("load_offset_reset", 32'(offset), 32'd7);

    // MULT dd=1 aa=3, unit_done five cycles after start
    exp_q.push_back(ev(4'd4, 12'd3, 16'd0));
    exp_q.push_back(ev(4'd3, 12'd0, 16'h0002));
    push_done();
    send_instr(8'h7F);
    check_eq("mult_out_sel", 32'(out_sel), 32'd3);
    check_eq("mult_aa_sel", 32'(aa_sel), 32'd3);
    repeat (5) tick();
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    wait_ready("mult_end");

    // ADD in place dd=aa=2, unit_done coincident with unit_start
    exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
    exp_q.push_back(ev(4'd3, 12'd0, 16'h0004));
    push_done();
    send_instr(8'hAC);
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    wait_ready("add_end");

    // SUB dd=0 aa=3
    exp_q.push_back(ev(4'd4, 12'd2, 16'd0));
    exp_q.push_back(ev(4'd3, 12'd0, 16'h0001));
    push_done();
    send_instr(8'h3E);
    repeat (2) tick();
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    wait_ready("sub_end");

    // COPY dd=0 aa=1
    exp_q.push_back(ev(4'd3, 12'd1, 16'h0001));
    push_done();
    send_instr(8'h15);
    check_eq("copy_we", 32'(bank_we), 32'h1);
    check_eq("copy_in_sel", 32'(bram_in_sel), 32'd1);
    check_eq("copy_done_early", 32'(done), 32'd0);
    tick();
    check_eq("copy_we_after", 32'(bank_we), 32'd0);
    check_eq("copy_done", 32'(done), 32'd1);
    check_eq("copy_sels", 32'({aa_sel, dd_sel}), 32'b0100);
    check_eq("out_sel_hold", 32'(out_sel), 32'd2);

    // CLEAR dd=3
    exp_q.push_back(ev(4'd1, 12'd0, 16'h0008));
    push_done();
    send_instr(8'hC7);
    wait_ready("clear_end");

    // NOP
    push_done();
    send_instr(8'h00);
    check_eq("nop_busy", 32'(busy), 32'd0);
    check_eq("nop_done", 32'(done), 32'd1);
    tick();

    // UNLOAD dd=1, reset asserted during beat 20
    send_instr(8'h46);
    byte_ready = 1'b1;
    repeat (20) tick();
    check_eq("unl_offset_beat20", 32'(offset), 32'd167);
    check_eq("unl_no_be", 32'(bank_be), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(instr_ready), 32'd0);
    check_eq("abort_offset", 32'(offset), 32'd0);
    check_eq("abort_outs", 32'({bank_rst, bank_we, bank_be, unit_start, done, err}), 32'd0);
    byte_ready = 1'b0;
    exp_q.push_back(ev(4'd1, 12'd0, 16'hF));
    tick();
    #1 reset_n = 1'b1;
    wait_ready("reset2_idle");
    check_eq("reset2_offset", 32'(offset), 32'd7);

`ifdef MPU_OP_TIMEOUT_EN
    exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
    exp_q.push_back(ev(4'd6, 12'd0, 16'd0));
    send_instr(8'hAC);
    busy_cnt = 0;
    wait_ready("wd_end");
    check_eq("wd_exec_cycles", 32'(busy_cnt), 32'd1024);
    tick();
`endif

    // three-bank instance: out-of-range dd / aa
    byte_valid3 = 1'b1;
    check_eq("b3_ready", 32'(instr_ready3), 32'd1);
    instr3 = 8'hC4;
    instr_valid3 = 1'b1;
    tick();
    instr_valid3 = 1'b0;
    check_eq("b3_dd_err", 32'(err3), 32'd1);
    check_eq("b3_dd_busy", 32'(busy3), 32'd0);
    check_eq("b3_dd_enables", 32'({bank_we3, bank_be3, bank_rst3}), 32'd0);
    tick();
    check_eq("b3_err_pulse", 32'(err3), 32'd0);
    instr3 = 8'h34;
    instr_valid3 = 1'b1;
    tick();
    instr_valid3 = 1'b0;
    check_eq("b3_aa_err", 32'(err3), 32'd1);
    check_eq("b3_aa_enables", 32'({bank_we3, bank_be3, bank_rst3}), 32'd0);
    tick();
    instr3 = 8'h84;
    instr_valid3 = 1'b1;
    tick();
    instr_valid3 = 1'b0;
    check_eq("b3_ok_err", 32'(err3), 32'd0);
    check_eq("b3_ok_be", 32'(bank_be3), 32'b100);
    byte_valid3 = 1'b0;

    repeat (3) tick();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
